// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operand memory: FSM state encoding
// and operator codes.
package calc_pkg;

  typedef enum logic [2:0] {
    ENTER_A  = 3'd0,
    OP_SET   = 3'd1,
    ENTER_B  = 3'd2,
    WAIT_RES = 3'd3,
    RESULT   = 3'd4
  } calc_state_e;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

endpackage

// File: rtl/calc_digit_shift.sv
// One operand register with its digit count: clear, parallel load, shift a
// digit in from the right (blocked when full) and shift a digit out.
module calc_digit_shift #(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned DIGIT_W = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clr,
  input  logic                               load,
  input  logic [DIGITS*DIGIT_W-1:0]          load_val,
  input  logic [$clog2(DIGITS+1)-1:0]        load_cnt,
  input  logic                               shift_in,
  input  logic [DIGIT_W-1:0]                 digit,
  input  logic                               shift_out,
  output logic [DIGITS*DIGIT_W-1:0]          operand,
  output logic [$clog2(DIGITS+1)-1:0]        count,
  output logic                               full
);

  localparam int unsigned OPND_W = DIGITS * DIGIT_W;
  localparam int unsigned CNT_W  = $clog2(DIGITS + 1);

  logic [OPND_W-1:0] operand_q, operand_d;
  logic [CNT_W-1:0]  count_q, count_d;

  assign full    = (count_q == CNT_W'(DIGITS));
  assign operand = operand_q;
  assign count   = count_q;

  always_comb begin
    operand_d = operand_q;
    count_d   = count_q;
    if (clr) begin
      operand_d = '0;
      count_d   = '0;
    end else if (load) begin
      operand_d = load_val;
      count_d   = load_cnt;
    end else if (shift_in) begin
      if (!full) begin
        operand_d = (operand_q << DIGIT_W) | OPND_W'(digit);
        count_d   = count_q + CNT_W'(1);
      end
    end else if (shift_out) begin
      operand_d = operand_q >> DIGIT_W;
      if (count_q != '0) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      operand_q <= '0;
      count_q   <= '0;
    end else begin
      operand_q <= operand_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: rtl/calc_operand_mem.sv
// Calculator operand memory: collects operands A/B from key digits, latches the
// operator and hands off to the ALU. Define CALC_MEM_BACKSPACE_EN for backspace.
module calc_operand_mem
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned OP_W    = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           digit_valid,
  input  logic [DIGIT_W-1:0]             digit,
  input  logic                           op_valid,
  input  logic [OP_W-1:0]                op_code,
  input  logic                           equ_valid,
  input  logic                           clear,
`ifdef CALC_MEM_BACKSPACE_EN
  input  logic                           bksp,
`endif
  input  logic [DIGITS*DIGIT_W-1:0]      res,
  input  logic                           res_valid,
  output logic                           calc_req,
  output logic [DIGITS*DIGIT_W-1:0]      save1,
  output logic [DIGITS*DIGIT_W-1:0]      save2,
  output logic [OP_W-1:0]                op_out,
  output logic [2:0]                     state,
  output logic [$clog2(DIGITS+1)-1:0]    digit_count,
  output logic                           overflow
);

  localparam int unsigned OPERAND_W = DIGITS * DIGIT_W;
  localparam int unsigned CNT_W     = $clog2(DIGITS + 1);

  calc_state_e state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic calc_req_q, calc_req_d;
  logic overflow_q, overflow_d;

  logic st_a, st_op, st_b, st_wait, st_res;
  logic ev_res, ev_equ, ev_op, ev_dig, ev_bksp;

  logic                 a_clr, a_load, a_shift_in, a_shift_out, a_full;
  logic [OPERAND_W-1:0] a_load_val, a_operand;
  logic [CNT_W-1:0]     a_load_cnt, a_count;
  logic                 b_clr, b_load, b_shift_in, b_shift_out, b_full;
  logic [OPERAND_W-1:0] b_load_val, b_operand;
  logic [CNT_W-1:0]     b_load_cnt, b_count;

  assign st_a    = (state_q == ENTER_A);
  assign st_op   = (state_q == OP_SET);
  assign st_b    = (state_q == ENTER_B);
  assign st_wait = (state_q == WAIT_RES);
  assign st_res  = (state_q == RESULT);

  // Each strobe only wins if it is meaningful in the current state and no
  // higher-priority strobe was accepted this cycle.
  assign ev_res = ~clear & res_valid & st_wait;
  assign ev_equ = ~clear & equ_valid & st_b;
  assign ev_op  = ~clear & op_valid & (st_a | st_b | st_res) & ~ev_equ;
  assign ev_dig = ~clear & digit_valid & ~st_wait & ~ev_equ & ~ev_op;
`ifdef CALC_MEM_BACKSPACE_EN
  assign ev_bksp = ~clear & bksp & (st_a | st_b) & ~ev_equ & ~ev_op & ~ev_dig;
`else
  assign ev_bksp = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ENTER_A;
      op_q       <= '0;
      calc_req_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      calc_req_q <= calc_req_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ENTER_A;
    end else if (ev_res) begin
      state_d = RESULT;
    end else if (ev_equ) begin
      state_d = WAIT_RES;
    end else if (ev_op) begin
      if (!st_b) state_d = OP_SET;
    end else if (ev_dig) begin
      if (st_op)       state_d = ENTER_B;
      else if (st_res) state_d = ENTER_A;
    end
  end

  always_comb begin
    a_clr       = clear;
    a_load      = ev_res | (ev_dig & st_res);
    a_load_val  = ev_res ? res : OPERAND_W'(digit);
    a_load_cnt  = ev_res ? '0 : CNT_W'(1);
    a_shift_in  = ev_dig & st_a;
    a_shift_out = ev_bksp & st_a;

    b_clr       = clear | ev_res;
    b_load      = ev_dig & st_op;
    b_load_val  = OPERAND_W'(digit);
    b_load_cnt  = CNT_W'(1);
    b_shift_in  = ev_dig & st_b;
    b_shift_out = ev_bksp & st_b;

    calc_req_d = ev_equ;

    op_d = op_q;
    if (clear)      op_d = '0;
    else if (ev_op) op_d = op_code;

    overflow_d = overflow_q;
    if (clear)                                             overflow_d = 1'b0;
    else if ((a_shift_in & a_full) | (b_shift_in & b_full)) overflow_d = 1'b1;
    else if (ev_bksp)                                      overflow_d = 1'b0;

    // The visible count follows whichever operand is being entered.
    unique case (state_q)
      OP_SET:            digit_count = '0;
      ENTER_B, WAIT_RES: digit_count = b_count;
      default:           digit_count = a_count;
    endcase
  end

  calc_digit_shift #(
    .DIGITS (DIGITS),
    .DIGIT_W(DIGIT_W)
  ) u_opnd_a (
    .clk      (clk),
    .rst      (rst),
    .clr      (a_clr),
    .load     (a_load),
    .load_val (a_load_val),
    .load_cnt (a_load_cnt),
    .shift_in (a_shift_in),
    .digit    (digit),
    .shift_out(a_shift_out),
    .operand  (a_operand),
    .count    (a_count),
    .full     (a_full)
  );

  calc_digit_shift #(
    .DIGITS (DIGITS),
    .DIGIT_W(DIGIT_W)
  ) u_opnd_b (
    .clk      (clk),
    .rst      (rst),
    .clr      (b_clr),
    .load     (b_load),
    .load_val (b_load_val),
    .load_cnt (b_load_cnt),
    .shift_in (b_shift_in),
    .digit    (digit),
    .shift_out(b_shift_out),
    .operand  (b_operand),
    .count    (b_count),
    .full     (b_full)
  );

  assign save1    = a_operand;
  assign save2    = b_operand;
  assign op_out   = op_q;
  assign calc_req = calc_req_q;
  assign overflow = overflow_q;
  assign state    = state_q;

endmodule

// File: doc/calc_operand_mem.md
CALC_OPERAND_MEM -- requirements
Module: calc_operand_mem

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning max digits per operand.
REQ-002 SHALL have parameter DIGIT_W, default 4, meaning bits per digit; OPERAND_W = DIGITS*DIGIT_W.
REQ-003 SHALL have parameter OP_W, default 2, meaning operator code width.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports digit_valid in 1 and digit in DIGIT_W: key digit strobe and value.
REQ-007 SHALL have ports op_valid in 1 and op_code in OP_W: operator strobe and code.
REQ-008 SHALL have ports equ_valid in 1 and clear in 1: equals strobe and clear-all.
REQ-009 SHALL have ports res in OPERAND_W and res_valid in 1: ALU result and its qualifier.
REQ-010 SHALL have output calc_req out 1: one-cycle request to the ALU.
REQ-011 SHALL have outputs save1 and save2 out OPERAND_W: operands A and B.
REQ-012 SHALL have output op_out out OP_W: latched operator.
REQ-013 SHALL have outputs state out 3, digit_count out $clog2(DIGITS+1), overflow out 1 (sticky).

Function
REQ-014 SHALL implement FSM states ENTER_A, OP_SET, ENTER_B, WAIT_RES, RESULT; reset state ENTER_A.
REQ-015 SHALL, on a digit in ENTER_A, set save1 = (save1 << DIGIT_W) | digit, truncated to OPERAND_W, and increment digit_count.
REQ-016 SHALL, on op_valid in ENTER_A, ENTER_B or RESULT, latch op_code into op_out, clear digit_count, and go to OP_SET; in ENTER_B, op_valid replaces the operator only.
REQ-017 SHALL, on a digit in OP_SET, clear save2, shift the digit in, set digit_count = 1, and go to ENTER_B; in ENTER_B digits shift into save2.
REQ-018 SHALL ignore any digit when digit_count == DIGITS, leave the operand unchanged, and set overflow.
REQ-019 SHALL, on equ_valid in ENTER_B, pulse calc_req for exactly one cycle and go to WAIT_RES; equ_valid in other states SHALL be ignored.
REQ-020 SHALL, on res_valid in WAIT_RES, load save1 = res, clear save2 and digit_count, and go to RESULT; res_valid in other states SHALL be ignored.
REQ-021 SHALL, in WAIT_RES, ignore digit, op_valid and equ_valid.
REQ-022 SHALL, on a digit in RESULT, set save1 = digit, set digit_count = 1, and go to ENTER_A.
REQ-023 SHALL apply same-cycle priority clear > res_valid > equ_valid > op_valid > digit_valid.
REQ-024 SHALL, on clear in any state including WAIT_RES, zero all outputs and go to ENTER_A; a later res_valid SHALL be discarded.
REQ-025 SHALL register all outputs; the effect of an input SHALL be visible one cycle after the sampling edge.

Reset
REQ-026 SHALL, with rst high at a clk edge, set save1 = save2 = 0, op_out = 0, calc_req = 0, overflow = 0, digit_count = 0, state = ENTER_A.
REQ-027 SHALL give rst priority over clear and over all strobes.

Configuration
REQ-028 SHALL, with CALC_MEM_BACKSPACE_EN defined, add input bksp (1 bit); in ENTER_A or ENTER_B, bksp SHALL shift the active operand right by DIGIT_W, decrement digit_count (floor 0), and clear overflow; bksp priority SHALL sit just below digit_valid.
REQ-029 SHALL, without CALC_MEM_BACKSPACE_EN, omit port bksp and all related logic.

Structure
REQ-030 SHALL place the state encoding enum and the operator code constants (ADD = 0, SUB = 1, MUL = 2, DIV = 3) in shared package calc_pkg.
REQ-031 SHALL instantiate sub-module calc_digit_shift twice (operand plus count, with load, shift-in, shift-out and clear), once for A and once for B.

Verification
REQ-032 SHALL cover: rst, then digits 1,2,3 -> save1 = 0x0123, digit_count = 3, state ENTER_A.
REQ-033 SHALL cover: digits 1,2,3,4,5 -> save1 = 0x1234, overflow = 1, digit_count = 4.
REQ-034 SHALL cover: 7, op 1, 2, equ -> calc_req high one cycle; res = 0x0005 with res_valid -> save1 = 0x0005, save2 = 0, state RESULT.
REQ-035 SHALL cover: in RESULT, op 0 then digit 3 -> op_out = 0, save2 = 0x0003, state ENTER_B (chaining).
REQ-036 SHALL cover: clear during WAIT_RES, then res_valid -> all outputs zero, state ENTER_A, result discarded.
REQ-037 SHALL cover, with CALC_MEM_BACKSPACE_EN defined: digits 4,5 then bksp -> save1 = 0x0004, digit_count = 1.
